// File: rtl/tank_pkg.sv
// Shared types and screen constants for the tank game datapath.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    BURST,
    COOLDOWN
  } shell_state_t;

  localparam logic [7:0] KEY_SPACE    = 8'h2C;
  localparam logic [9:0] SCREEN_Y_MIN = 10'd0;
  localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

  // Zero-extend a screen coordinate so bound arithmetic cannot wrap.
  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/shell_ctrl_if.sv
// Bundle between the shell controller and its neighbours (tank stage, mapper, collision).
// SHELL_HITCNT_EN adds the hit_count signal to the bundle.
interface shell_ctrl_if;
  logic [7:0] keycode;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic       hit;
  logic [9:0] ShellX;
  logic [9:0] ShellY;
  logic       shell_active;
  logic       burst;
  logic       ready;
`ifdef SHELL_HITCNT_EN
  logic [7:0] hit_count;

  modport master (
    output keycode, TankX, TankY, hit,
    input  ShellX, ShellY, shell_active, burst, ready, hit_count
  );
  modport slave (
    input  keycode, TankX, TankY, hit,
    output ShellX, ShellY, shell_active, burst, ready, hit_count
  );
`else
  modport master (
    output keycode, TankX, TankY, hit,
    input  ShellX, ShellY, shell_active, burst, ready
  );
  modport slave (
    input  keycode, TankX, TankY, hit,
    output ShellX, ShellY, shell_active, burst, ready
  );
`endif
endinterface

// File: rtl/shell_ctrl_key_edge.sv
// One-frame rising pulse when keycode starts matching KEY; shared with the tank movement stage.
module key_edge
  import tank_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_SPACE
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       pulse
);

  logic match;
  logic key_q;

  assign match = (keycode == KEY);
  assign pulse = match & ~key_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      key_q <= 1'b0;
    end else begin
      key_q <= match;
    end
  end

endmodule

// File: rtl/shell_ctrl.sv
// Per-tank shell controller: launch on fire press, fly, burst on hit, then reload cooldown.
// Define SHELL_HITCNT_EN to add a saturating hit_count output.
module shell_ctrl
  import tank_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY        = KEY_SPACE,
  parameter bit         SHELL_DIR       = 1'b0,
  parameter logic [9:0] SHELL_STEP      = 10'd4,
  parameter logic [9:0] SPAWN_OFS       = 10'd8,
  parameter logic [9:0] Y_MIN           = SCREEN_Y_MIN,
  parameter logic [9:0] Y_MAX           = SCREEN_Y_MAX,
  parameter logic [7:0] BURST_FRAMES    = 8'd16,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd30
) (
  input logic         frame_clk,
  input logic         Reset,
  shell_ctrl_if.slave bus
);

  shell_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [9:0]   shell_x_q, shell_x_d;
  logic [9:0]   shell_y_q, shell_y_d;
  logic         fire_edge;
  logic         spawn_ok;
  logic         at_bound;
  logic [9:0]   spawn_y;

  key_edge #(
    .KEY (FIRE_KEY)
  ) u_fire_edge (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (bus.keycode),
    .pulse     (fire_edge)
  );

  // Bound checks in 11 bits so neither spawn nor motion can wrap past the screen edge.
  always_comb begin
    if (SHELL_DIR) begin
      spawn_ok = !((ext11(bus.TankY) + ext11(SPAWN_OFS)) > ext11(Y_MAX));
      at_bound = (ext11(shell_y_q) + ext11(SHELL_STEP)) > ext11(Y_MAX);
      spawn_y  = bus.TankY + SPAWN_OFS;
    end else begin
      spawn_ok = !(ext11(bus.TankY) < (ext11(Y_MIN) + ext11(SPAWN_OFS)));
      at_bound = ext11(shell_y_q) < (ext11(Y_MIN) + ext11(SHELL_STEP));
      spawn_y  = bus.TankY - SPAWN_OFS;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shell_x_d = shell_x_q;
    shell_y_d = shell_y_q;
    unique case (state_q)
      IDLE: begin
        if (fire_edge && spawn_ok) begin
          state_d   = FLIGHT;
          shell_x_d = bus.TankX;
          shell_y_d = spawn_y;
        end
      end
      FLIGHT: begin
        if (bus.hit) begin
          state_d = BURST;
          cnt_d   = BURST_FRAMES - 8'd1;
        end else if (at_bound) begin
          state_d = COOLDOWN;
          cnt_d   = COOLDOWN_FRAMES - 8'd1;
        end else if (SHELL_DIR) begin
          shell_y_d = shell_y_q + SHELL_STEP;
        end else begin
          shell_y_d = shell_y_q - SHELL_STEP;
        end
      end
      BURST: begin
        if (cnt_q == 8'd0) begin
          state_d = COOLDOWN;
          cnt_d   = COOLDOWN_FRAMES - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      COOLDOWN: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      shell_x_q <= 10'd0;
      shell_y_q <= 10'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shell_x_q <= shell_x_d;
      shell_y_q <= shell_y_d;
    end
  end

  assign bus.ShellX       = shell_x_q;
  assign bus.ShellY       = shell_y_q;
  assign bus.shell_active = (state_q == FLIGHT);
  assign bus.burst        = (state_q == BURST);
  assign bus.ready        = (state_q == IDLE);

`ifdef SHELL_HITCNT_EN
  logic [7:0] hit_count_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      hit_count_q <= 8'd0;
    end else if ((state_q == FLIGHT) && bus.hit && (hit_count_q != 8'hFF)) begin
      hit_count_q <= hit_count_q + 8'd1;
    end
  end

  assign bus.hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_shell_ctrl.sv
// Scoreboard bench for shell_ctrl: expected {ShellX, ShellY, active, burst, ready} per frame.
module tb_shell_ctrl;
  import tank_pkg::*;

  localparam logic [7:0] KEY = 8'h2C;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  int   errors    = 0;
  int   checks    = 0;
  int   hits_exp  = 0;
  logic [22:0] exp_q[$];

  shell_ctrl_if bus ();

  shell_ctrl u_dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [22:0] pack(input logic [9:0] x, input logic [9:0] y,
                                       input logic a, input logic b, input logic r);
    return {x, y, a, b, r};
  endfunction

  function automatic logic [22:0] obs();
    return {bus.ShellX, bus.ShellY, bus.shell_active, bus.burst, bus.ready};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] e;
    bus.keycode = 8'h00;
    bus.TankX   = 10'd0;
    bus.TankY   = 10'd0;
    bus.hit     = 1'b0;
    Reset       = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pack(10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
      if (i > 0) tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  // Key held 3 frames fires once; fly to y=0, 30 frames cooldown; press in cooldown ignored.
  task automatic test_launch_fly_up();
    logic [22:0] e;
    int n;
    for (int y = 392; y >= 0; y -= 4) exp_q.push_back(pack(10'd350, 10'(y), 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 30; i++) exp_q.push_back(pack(10'd350, 10'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(pack(10'd350, 10'd0, 1'b0, 1'b0, 1'b1));
    n = exp_q.size();
    bus.TankX = 10'd350;
    bus.TankY = 10'd400;
    for (int i = 0; i < n; i++) begin
      bus.keycode = (i < 3 || i >= 105) ? KEY : 8'h00;
      if (i == 10) begin
        bus.TankX = 10'd20;
        bus.TankY = 10'd100;
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL fly_up[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_repress();
    logic [22:0] e;
    bus.keycode = 8'h00;
    exp_q.push_back(pack(10'd350, 10'd0, 1'b0, 1'b0, 1'b1));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL release: got %h want %h", obs(), e);
    end
    bus.keycode = KEY;
    bus.TankX   = 10'd120;
    bus.TankY   = 10'd300;
    exp_q.push_back(pack(10'd120, 10'd292, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL repress: got %h want %h", obs(), e);
    end
  endtask

  // Hit in flight frame 5: 16 burst frames frozen at y=280, 30 cooldown, then ready.
  task automatic test_hit();
    logic [22:0] e;
    for (int i = 0; i < 50; i++) begin
      if (i < 3)       e = pack(10'd120, 10'(288 - 4 * i), 1'b1, 1'b0, 1'b0);
      else if (i < 19) e = pack(10'd120, 10'd280, 1'b0, 1'b1, 1'b0);
      else if (i < 49) e = pack(10'd120, 10'd280, 1'b0, 1'b0, 1'b0);
      else             e = pack(10'd120, 10'd280, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(e);
      bus.keycode = (i == 0) ? KEY : 8'h00;
      bus.hit     = (i == 3 || i == 10 || i == 30);
      if (i == 1) bus.TankX = 10'd400;
      if (i == 3) hits_exp++;
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL hit[%0d]: got %h want %h", i, obs(), e);
      end
    end
    bus.hit = 1'b0;
`ifdef SHELL_HITCNT_EN
    checks++;
    if (bus.hit_count !== 8'(hits_exp)) begin
      errors++;
      $display("FAIL hit_count_one: got %0d want %0d", bus.hit_count, hits_exp);
    end
`endif
  endtask

  // TankY=5 rejected; TankY=8 launches at 0; hit beats bound; reset aborts burst.
  task automatic test_reject_bounds();
    logic [22:0] e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: e = pack(10'd120, 10'd280, 1'b0, 1'b0, 1'b1);
        1: e = pack(10'd120, 10'd280, 1'b0, 1'b0, 1'b1);
        2: e = pack(10'd77, 10'd0, 1'b1, 1'b0, 1'b0);
        3: e = pack(10'd77, 10'd0, 1'b0, 1'b1, 1'b0);
        default: e = pack(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
      endcase
      exp_q.push_back(e);
      bus.keycode = (i == 0 || i == 2) ? KEY : 8'h00;
      bus.TankX   = 10'd77;
      bus.TankY   = (i == 0) ? 10'd5 : 10'd8;
      bus.hit     = (i == 3);
      Reset       = (i == 4);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL bounds[%0d]: got %h want %h", i, obs(), e);
      end
    end
    Reset    = 1'b0;
    bus.hit  = 1'b0;
    hits_exp = 0;
  endtask

  task automatic test_reset_mid_flight();
    logic [22:0] e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: e = pack(10'd5, 10'd292, 1'b1, 1'b0, 1'b0);
        1: e = pack(10'd5, 10'd288, 1'b1, 1'b0, 1'b0);
        default: e = pack(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
      endcase
      exp_q.push_back(e);
      bus.keycode = (i == 0) ? KEY : 8'h00;
      bus.TankX   = 10'd5;
      bus.TankY   = 10'd300;
      Reset       = (i == 2);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_flight[%0d]: got %h want %h", i, obs(), e);
      end
    end
    Reset = 1'b0;
  endtask

`ifdef SHELL_HITCNT_EN
  task automatic test_hitcnt();
    bus.TankY = 10'd300;
    for (int k = 0; k < 260; k++) begin
      bus.keycode = 8'h00;
      tick();
      bus.keycode = KEY;
      tick();
      bus.hit = 1'b1;
      tick();
      bus.hit = 1'b0;
      if (hits_exp < 255) hits_exp++;
      for (int j = 0; j < 46; j++) tick();
      if (k == 2 || k == 259) begin
        checks++;
        if (bus.hit_count !== 8'(hits_exp) || bus.ready !== 1'b1) begin
          errors++;
          $display("FAIL hit_count[%0d]: got %0d ready %b want %0d ready 1",
                   k, bus.hit_count, bus.ready, hits_exp);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_launch_fly_up();
    test_repress();
    test_hit();
    test_reject_bounds();
    test_reset_mid_flight();
`ifdef SHELL_HITCNT_EN
    test_hitcnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
